// File: rtl/gray_to_binary_4bit_pkg.sv
// Shared definitions for the Gray-to-binary converter and anything that
// needs a reference Gray decode at the default word width.
package gray_to_binary_4bit_pkg;

    localparam int GTB_DEFAULT_WIDTH = 4;

    typedef logic [GTB_DEFAULT_WIDTH-1:0] gtb_word_t;

    // Each binary bit is the running XOR of the Gray bits from the MSB down.
    function automatic gtb_word_t gray2bin(input gtb_word_t g);
        gtb_word_t b;
        b[GTB_DEFAULT_WIDTH-1] = g[GTB_DEFAULT_WIDTH-1];
        for (int i = GTB_DEFAULT_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary_4bit_gray2bin_comb.sv
// Parameterized combinational Gray-to-binary converter.
// Each output bit is the XOR of all Gray bits at or above its position.
module gray2bin_comb
    import gray_to_binary_4bit_pkg::*;
#(
    parameter int WIDTH = GTB_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Written as independent reductions so no output bit feeds another.
    for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_to_binary_4bit.sv
// Registered Gray-to-binary converter with a step checker that flags
// consecutive accepted words differing in more than one bit.
module gray_to_binary_4bit
    import gray_to_binary_4bit_pkg::*;
#(
    parameter int WIDTH = GTB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic [WIDTH-1:0] binary,
    output logic             step_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    logic [WIDTH-1:0] conv_bin;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             have_prev_q, have_prev_d;
    logic             out_valid_q, out_valid_d;
    logic             step_err_q, step_err_d;

    gray2bin_comb #(
        .WIDTH (WIDTH)
    ) u_conv (
        .gray_i (gray),
        .bin_o  (conv_bin)
    );

    // Idle cycles drop the strobes but keep the last word and history.
    always_comb begin
        binary_d    = binary_q;
        prev_gray_d = prev_gray_q;
        have_prev_d = have_prev_q;
        out_valid_d = 1'b0;
        step_err_d  = 1'b0;
        if (in_valid) begin
            binary_d    = conv_bin;
            out_valid_d = 1'b1;
            step_err_d  = have_prev_q && (popcount(gray ^ prev_gray_q) > CNT_W'(1));
            prev_gray_d = gray;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_q    <= '0;
            prev_gray_q <= '0;
            have_prev_q <= 1'b0;
            out_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            binary_q    <= binary_d;
            prev_gray_q <= prev_gray_d;
            have_prev_q <= have_prev_d;
            out_valid_q <= out_valid_d;
            step_err_q  <= step_err_d;
        end
    end

    assign binary    = binary_q;
    assign out_valid = out_valid_q;
    assign step_err  = step_err_q;

endmodule

// File: tb/tb_gray_to_binary_4bit.sv
// Scoreboard bench for gray_to_binary_4bit: stimulus pushes model results,
// a monitor pops and compares whenever the DUT presents a word.
module tb_gray_to_binary_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] gray;
    logic       out_valid;
    logic [3:0] binary;
    logic       step_err;

    gray_to_binary_4bit #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .gray      (gray),
        .out_valid (out_valid),
        .binary    (binary),
        .step_err  (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bin;
        logic       err;
        int         stamp;
    } exp_t;

    exp_t       sbq[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [3:0] hold_bin = 4'b0000;

    // Reference model state (stimulus side only)
    logic [3:0] m_prev = 4'b0000;
    bit         m_have = 1'b0;

    // Decode by searching the Gray sequence: n-th code is n ^ (n >> 1).
    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        for (int n = 0; n < 16; n++) begin
            if (4'(n ^ (n >> 1)) == g) return 4'(n);
        end
        return 4'b0000;
    endfunction

    function automatic logic [3:0] ref_gray(input int n);
        return 4'((n & 15) ^ ((n & 15) >> 1));
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: checks on falling clock edges, and immediately on reset assertion.
    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            check("rst_binary", binary, 4'b0000);
            check("rst_out_valid", {3'b000, out_valid}, 4'b0000);
            check("rst_step_err", {3'b000, step_err}, 4'b0000);
            hold_bin = 4'b0000;
            sbq.delete();
        end else begin
            cyc++;
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: out_valid=1 with binary=%b, expected no output", binary);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("binary", binary, e.bin);
                    check("step_err", {3'b000, step_err}, {3'b000, e.err});
                    hold_bin = e.bin;
                end
            end else begin
                check("out_valid_idle", {3'b000, out_valid}, 4'b0000);
                check("idle_step_err", {3'b000, step_err}, 4'b0000);
                check("idle_binary_hold", binary, hold_bin);
            end
            if (sbq.size() > 0 && cyc > sbq[0].stamp + 2) begin
                n_total++;
                $display("FAIL timeout: no output for expected binary %b, expected out_valid=1", sbq[0].bin);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic send(input bit v, input logic [3:0] g);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid = v;
        gray     = g;
        if (v) begin
            e.bin   = ref_bin(g);
            e.err   = m_have && ($countones(g ^ m_prev) > 1);
            e.stamp = cyc;
            sbq.push_back(e);
            m_prev = g;
            m_have = 1'b1;
        end
    endtask

    logic [3:0] spots[5]  = '{4'b0110, 4'b1111, 4'b1010, 4'b1001, 4'b1000};
    logic [3:0] skips[3]  = '{4'b1110, 4'b1010, 4'b1001};

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        gray     = 4'b0000;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Full Gray sequence back-to-back
        for (int n = 0; n < 16; n++) send(1'b1, ref_gray(n));
        send(1'b0, 4'b0000);

        for (int i = 0; i < 5; i++) begin
            send(1'b1, spots[i]);
            send(1'b0, 4'b1111);
        end

        for (int i = 0; i < 3; i++) send(1'b1, skips[i]);

        // Gaps with a repeated word
        send(1'b0, 4'b0000);
        send(1'b1, 4'b0101);
        send(1'b0, 4'b1111);
        send(1'b0, 4'b0011);
        send(1'b1, 4'b0101);
        send(1'b0, 4'b0000);

        // Reset mid-stream clears history
        send(1'b1, 4'b0011);
        send(1'b0, 4'b0000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        m_prev = 4'b0000;
        m_have = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(1'b1, 4'b1100);

        // Randomized mix of adjacent steps, repeats and arbitrary jumps
        for (int k = 0; k < 300; k++) begin
            bit         v;
            logic [3:0] g;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: g = 4'($urandom_range(0, 15));
                1: g = m_prev;
                2: g = ref_gray(int'(ref_bin(m_prev)) + 1);
                default: g = m_prev ^ (4'b0001 << $urandom_range(0, 3));
            endcase
            send(v, g);
        end

        repeat (4) send(1'b0, 4'b0000);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_4bit.md
# gray_to_binary_4bit

Registered Gray-code-to-binary converter for position/counter values that cross clock domains or come from Gray-coded encoders. Each accepted Gray word is converted to plain binary and presented one clock later, with a valid strobe. The block also flags non-adjacent steps between consecutive accepted inputs, which indicates a skipped or corrupted encoder/counter sample. It sits directly after the Gray-code source and before any binary arithmetic consumer.

## Interface
- `WIDTH`, default 4: Gray/binary word width; legal range ≥ 2.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: `gray` is sampled on this edge when high.
- `gray`  input  WIDTH: Gray-coded input word.
- `out_valid`  output  1: high for one cycle per accepted input.
- `binary`  output  WIDTH: converted binary word; holds its value between updates.
- `step_err`  output  1: the accepted word differed from the previous accepted word in more than one bit; qualified by `out_valid`.

## Operation
- Conversion:
  - `b[WIDTH-1] = g[WIDTH-1]`.
  - `b[i] = b[i+1] XOR g[i]` for i = WIDTH-2 down to 0, which is equivalent to the XOR of all `g` bits at or above i.
  - Implemented as a purely combinational prefix-XOR.
- On an edge with `in_valid`=1:
  - `binary` <= conv(`gray`).
  - `out_valid` <= 1.
  - `step_err` <= (have_prev AND popcount(`gray` XOR prev_gray) > 1).
  - prev_gray <= `gray`; have_prev <= 1.
- On an edge with `in_valid`=0:
  - `out_valid` <= 0.
  - `step_err` <= 0.
  - `binary`, prev_gray and have_prev hold.
- Repeated identical input (Hamming distance 0) is not an error. A distance of exactly 1 is not an error.
- The first accepted word after reset never raises `step_err`.
- All-ones and all-zeros inputs are handled normally. There is no wrap special case, because Gray wrap (e.g. 1000→0000) is single-bit.

## Timing
- Latency: 1 clock from the `in_valid` sample to `out_valid`/`binary`/`step_err`.
- Throughput: one word per clock; back-to-back `in_valid` is fully supported.
- No backpressure.
- Reset, asserted at any time, immediately forces:
  - `binary`=0, `out_valid`=0, `step_err`=0
  - prev_gray=0, have_prev=0
- Reset asserted mid-stream discards history. The next accepted word is treated as the first.
- Reset deassertion is synchronized externally. The block assumes `rst_n` is released away from the `clk` edge.
- `gray` must be stable around the sampling edge. The block does not synchronize `gray` itself.

## Structure
- The shared package holds:
  - `GTB_DEFAULT_WIDTH` = 4.
  - A function `gray2bin(logic [WIDTH-1:0])` that is reusable by other blocks and by the bench reference model.
- One sub-module is natural: `gray2bin_comb`, a parameterized combinational prefix-XOR converter.
- The top level adds the output registers, history register and popcount-based step checker.

## Test plan
- Reset with `rst_n`=0 asynchronously mid-cycle -> `binary`=0000, `out_valid`=0, `step_err`=0 immediately, without waiting for a clock edge.
- Full 4-bit Gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, one word per clock with `in_valid`=1:
  - `binary` equals 0000..1111 in order, each one cycle after its input.
  - `out_valid` stays high throughout.
  - `step_err` stays 0 throughout.
- Spot conversions: 0110->0100, 1111->1010, 1010->1100, 1001->1110, 1000->1111.
- Skipped step: accept 1110, then 1010, then 1001.
  - `step_err` is 0 for 1110->1010 (single-bit change).
  - `step_err` is 1 for 1010->1001 (two bits differ); `binary`=1110 in that cycle.
- Gaps: `in_valid` pulses with idle cycles between them:
  - During idle cycles, `out_valid`=0 and `step_err`=0, and `binary` holds the last value.
  - A repeated word 0101,0101 gives `step_err`=0 and `binary`=0110.
- Reset mid-stream after 0011, then accept 1100 -> `step_err`=0 (history cleared) and `binary`=1000.
